// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its busy-bit scoreboard.
// Holds default sizes and the helper functions reused by other scoreboards.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int DEPTH_DEF = 32;
  // Widest busy vector the shared popcount accepts; narrower vectors are zero-extended.
  localparam int POP_W = 256;

  function automatic int aw_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned n;
    n = 32'd0;
    for (int k = 0; k < POP_W; k++) begin
      n = n + {31'd0, v[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Bus between decode/writeback and the register file.
// The master drives the addresses and strobes; the slave returns data, busy flags and the count.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1
);
  localparam int AW = aw_of(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD*XLEN-1:0]  rd_data;
  logic [NREAD-1:0]       rd_busy;
  logic [NWRITE-1:0]      wr_en;
  logic [NWRITE*AW-1:0]   wr_addr;
  logic [NWRITE*XLEN-1:0] wr_data;
  logic                   iss_en;
  logic [AW-1:0]          iss_addr;
  logic                   flush;
  logic [CW-1:0]          busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, busy_cnt
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register with an outstanding producer.
// Flush beats issue; an issue beats a same-cycle writeback clear of the same register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NWRITE   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = aw_of(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWRITE-1:0]    wr_en,
  input  logic [NWRITE*AW-1:0] wr_addr,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic                 flush,
  output logic [DEPTH-1:0]     busy,
  output logic [CW-1:0]        busy_cnt
);

  localparam logic [DEPTH-1:0] KEEP_MASK = {{(DEPTH-1){1'b1}}, (ZERO_REG == 0) ? 1'b1 : 1'b0};

  logic [DEPTH-1:0] busy_r;
  logic [CW-1:0]    busy_cnt_r;
  logic [DEPTH-1:0] clr_mask_s;
  logic [DEPTH-1:0] set_mask_s;
  logic [DEPTH-1:0] busy_nxt_s;
  logic [POP_W-1:0] pop_in_s;
  logic [CW-1:0]    cnt_nxt_s;

  // Next busy vector and its population count.
  always_comb begin
    clr_mask_s = '0;
    for (int w = 0; w < NWRITE; w++) begin
      clr_mask_s = clr_mask_s | ({{(DEPTH-1){1'b0}}, wr_en[w]} << wr_addr[w*AW +: AW]);
    end
    set_mask_s = {{(DEPTH-1){1'b0}}, iss_en} << iss_addr;
    busy_nxt_s = flush ? '0 : (((busy_r & ~clr_mask_s) | set_mask_s) & KEEP_MASK);
    pop_in_s = '0;
    pop_in_s[DEPTH-1:0] = busy_nxt_s;
    cnt_nxt_s = CW'(popcount(pop_in_s));
  end

  // Busy bits and count update on the same edge so the count never lags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r     <= '0;
      busy_cnt_r <= '0;
    end else begin
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= cnt_nxt_s;
    end
  end

  assign busy     = busy_r;
  assign busy_cnt = busy_cnt_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write-to-read bypass and busy masking.
// The scoreboard sub-module tracks which registers still have an outstanding producer.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 1,
  parameter int ZERO_REG = 1
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  localparam int AW = aw_of(DEPTH);

  logic [XLEN-1:0]  mem_r [DEPTH];
  logic [DEPTH-1:0] busy_s;

  // Register array; later ports overwrite earlier ones, so the highest index wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_r[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NWRITE; w++) begin
        if (bus.wr_en[w] && !((ZERO_REG != 0) && (bus.wr_addr[w*AW +: AW] == '0))) begin
          mem_r[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NWRITE   (NWRITE),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .flush    (bus.flush),
    .busy     (busy_s),
    .busy_cnt (bus.busy_cnt)
  );

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   ra_s;
    logic [XLEN-1:0] data_s;
    logic            hit_s;

    assign ra_s = bus.rd_addr[i*AW +: AW];

    // Bypass scan: the highest-indexed matching write port supplies the data.
    always_comb begin
      data_s = mem_r[ra_s];
      hit_s  = 1'b0;
      for (int w = 0; w < NWRITE; w++) begin
        data_s = (bus.wr_en[w] && (bus.wr_addr[w*AW +: AW] == ra_s)) ?
                 bus.wr_data[w*XLEN +: XLEN] : data_s;
        hit_s  = hit_s | (bus.wr_en[w] && (bus.wr_addr[w*AW +: AW] == ra_s));
      end
    end

    assign bus.rd_data[i*XLEN +: XLEN] = ((ZERO_REG != 0) && (ra_s == '0)) ? '0 : data_s;
    // A same-cycle writeback releases the reader along with the bypassed value.
    assign bus.rd_busy[i] = busy_s[ra_s] & ~hit_s;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with two read and two write ports, register 0 hardwired.
// Each task drives one scenario and compares against hand-computed values.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_if #(.XLEN(32), .DEPTH(32), .NREAD(2), .NWRITE(2)) bus ();

  regfile_mp #(
    .XLEN(32), .DEPTH(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en    = 2'b00;
    bus.wr_addr  = 10'd0;
    bus.wr_data  = 64'd0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = 5'd0;
    bus.flush    = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.rd_addr = {5'd2, 5'd1};
    #2 rst = 1'b1;
    #2;
    checks++; if (bus.rd_data !== 64'd0) begin errors++; $display("FAIL reset_rd_data got %h exp %h", bus.rd_data, 64'd0); end
    checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL reset_rd_busy got %b exp %b", bus.rd_busy, 2'b00); end
    checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_busy_cnt got %0d exp %0d", bus.busy_cnt, 6'd0); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    bus.rd_addr = {5'd4, 5'd5};
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, 5'd5};
    bus.wr_data = {32'd0, 32'hDEADBEEF};
    #1;
    checks++; if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_same_cycle got %h exp %h", bus.rd_data[31:0], 32'hDEADBEEF); end
    checks++; if (bus.rd_data[63:32] !== 32'd0) begin errors++; $display("FAIL bypass_other_port got %h exp %h", bus.rd_data[63:32], 32'd0); end
    step();
    idle();
    #1;
    checks++; if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_stored got %h exp %h", bus.rd_data[31:0], 32'hDEADBEEF); end
  endtask

  task automatic test_zero_reg();
    bus.rd_addr  = {5'd0, 5'd0};
    bus.wr_en    = 2'b01;
    bus.wr_addr  = {5'd0, 5'd0};
    bus.wr_data  = {32'd0, 32'h12345678};
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd0;
    #1;
    checks++; if (bus.rd_data[31:0] !== 32'd0) begin errors++; $display("FAIL zero_bypass got %h exp %h", bus.rd_data[31:0], 32'd0); end
    step();
    idle();
    #1;
    checks++; if (bus.rd_data[31:0] !== 32'd0) begin errors++; $display("FAIL zero_stored got %h exp %h", bus.rd_data[31:0], 32'd0); end
    checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL zero_never_busy got %0d exp %0d", bus.busy_cnt, 6'd0); end
  endtask

  task automatic test_multi_write();
    bus.rd_addr = {5'd7, 5'd5};
    bus.wr_en   = 2'b11;
    bus.wr_addr = {5'd7, 5'd7};
    bus.wr_data = {32'h22, 32'h11};
    #1;
    checks++; if (bus.rd_data[63:32] !== 32'h22) begin errors++; $display("FAIL multi_bypass got %h exp %h", bus.rd_data[63:32], 32'h22); end
    step();
    idle();
    #1;
    checks++; if (bus.rd_data[63:32] !== 32'h22) begin errors++; $display("FAIL multi_stored got %h exp %h", bus.rd_data[63:32], 32'h22); end
  endtask

  task automatic test_busy();
    bus.rd_addr  = {5'd5, 5'd3};
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd3;
    #1;
    checks++; if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL busy_issue_cycle got %b exp %b", bus.rd_busy[0], 1'b0); end
    step();
    idle();
    #1;
    checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL busy_after_issue got %b exp %b", bus.rd_busy[0], 1'b1); end
    checks++; if (bus.busy_cnt !== 6'd1) begin errors++; $display("FAIL busy_cnt_one got %0d exp %0d", bus.busy_cnt, 6'd1); end
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, 5'd3};
    bus.wr_data = {32'd0, 32'h33};
    #1;
    checks++; if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL busy_wb_release got %b exp %b", bus.rd_busy[0], 1'b0); end
    checks++; if (bus.rd_data[31:0] !== 32'h33) begin errors++; $display("FAIL busy_wb_data got %h exp %h", bus.rd_data[31:0], 32'h33); end
    step();
    idle();
    #1;
    checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL busy_cnt_zero got %0d exp %0d", bus.busy_cnt, 6'd0); end
    checks++; if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL busy_cleared got %b exp %b", bus.rd_busy[0], 1'b0); end
  endtask

  task automatic test_set_wins();
    bus.rd_addr  = {5'd5, 5'd9};
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd9;
    step();
    idle();
    #1;
    checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL setwin_pre_busy got %b exp %b", bus.rd_busy[0], 1'b1); end
    bus.wr_en    = 2'b10;
    bus.wr_addr  = {5'd9, 5'd0};
    bus.wr_data  = {32'h99, 32'd0};
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd9;
    #1;
    checks++; if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL setwin_same_cycle got %b exp %b", bus.rd_busy[0], 1'b0); end
    step();
    idle();
    #1;
    checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL setwin_next_cycle got %b exp %b", bus.rd_busy[0], 1'b1); end
    checks++; if (bus.busy_cnt !== 6'd1) begin errors++; $display("FAIL setwin_cnt got %0d exp %0d", bus.busy_cnt, 6'd1); end
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, 5'd9};
    bus.wr_data = {32'd0, 32'h99};
    step();
    idle();
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 3; r++) begin
      bus.iss_en   = 1'b1;
      bus.iss_addr = 5'(r);
      step();
    end
    idle();
    bus.rd_addr = {5'd4, 5'd2};
    #1;
    checks++; if (bus.busy_cnt !== 6'd3) begin errors++; $display("FAIL flush_pre_cnt got %0d exp %0d", bus.busy_cnt, 6'd3); end
    checks++; if (bus.rd_busy !== 2'b01) begin errors++; $display("FAIL flush_pre_busy got %b exp %b", bus.rd_busy, 2'b01); end
    bus.flush    = 1'b1;
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd4;
    step();
    idle();
    #1;
    checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL flush_cnt got %0d exp %0d", bus.busy_cnt, 6'd0); end
    checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL flush_busy got %b exp %b", bus.rd_busy, 2'b00); end
  endtask

  task automatic test_write_nonbusy();
    bus.rd_addr = {5'd10, 5'd10};
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, 5'd10};
    bus.wr_data = {32'd0, 32'hA5A5A5A5};
    step();
    idle();
    #1;
    checks++; if (bus.rd_data[63:32] !== 32'hA5A5A5A5) begin errors++; $display("FAIL nonbusy_data got %h exp %h", bus.rd_data[63:32], 32'hA5A5A5A5); end
    checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL nonbusy_cnt got %0d exp %0d", bus.busy_cnt, 6'd0); end
  endtask

  task automatic test_reset_mid();
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd11;
    step();
    bus.iss_addr = 5'd12;
    bus.rd_addr  = {5'd11, 5'd7};
    bus.wr_en    = 2'b11;
    bus.wr_addr  = {5'd21, 5'd20};
    bus.wr_data  = {32'h55, 32'h44};
    #1;
    checks++; if (bus.rd_busy !== 2'b10) begin errors++; $display("FAIL midrst_pre_busy got %b exp %b", bus.rd_busy, 2'b10); end
    rst = 1'b1;
    #1;
    checks++; if (bus.rd_data !== 64'd0) begin errors++; $display("FAIL midrst_rd_data got %h exp %h", bus.rd_data, 64'd0); end
    checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL midrst_rd_busy got %b exp %b", bus.rd_busy, 2'b00); end
    checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL midrst_cnt got %0d exp %0d", bus.busy_cnt, 6'd0); end
    step();
    idle();
    rst = 1'b0;
    bus.rd_addr = {5'd21, 5'd20};
    #1;
    checks++; if (bus.rd_data !== 64'd0) begin errors++; $display("FAIL midrst_no_write got %h exp %h", bus.rd_data, 64'd0); end
    checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL midrst_no_issue got %0d exp %0d", bus.busy_cnt, 6'd0); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_multi_write();
    test_busy();
    test_set_wins();
    test_flush();
    test_write_nonbusy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with write-to-read bypass and an integrated busy-bit scoreboard. It sits between the decode and writeback stages of the pipeline. It serves NREAD read ports, such as rs1/rs2/rs3, and NWRITE writeback ports, such as ALU and load, in the same cycle. It tracks registers with an outstanding producer so decode can stall on a read-after-write hazard.

## Interface
Parameters:
- XLEN, 32, data width of each register
- DEPTH, 32, number of registers (power of two); AW = $clog2(DEPTH)
- NREAD, 2, number of read ports
- NWRITE, 1, number of write ports
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never busy

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd_data  out  NREAD*XLEN  read data (combinational)
- rd_busy  out  NREAD  requested register still has an outstanding producer
- wr_en  in  NWRITE  write strobe per port
- wr_addr  in  NWRITE*AW  write addresses
- wr_data  in  NWRITE*XLEN  write data
- iss_en  in  1  an instruction with a destination issues this cycle
- iss_addr  in  AW  that instruction's destination
- flush  in  1  clears all busy bits (pipeline flush)
- busy_cnt  out  $clog2(DEPTH+1)  number of busy registers

## Operation
- Register array:
  - On the rising edge, each port with wr_en=1 writes wr_data to wr_addr.
  - If several ports write the same address in the same cycle, the highest-indexed port wins.
- Read path: rd_data[i] is selected in this order.
  - 0, if ZERO_REG=1 and rd_addr[i]=0.
  - Otherwise, the data of the highest-indexed write port with wr_en=1 and wr_addr=rd_addr[i] (same-cycle bypass).
  - Otherwise, the stored value.
- Scoreboard: one busy bit per register; next state is computed in this order:
  1. flush=1 clears every bit. iss_en is ignored in that cycle.
  2. Otherwise, any wr_en port whose address matches clears that bit.
  3. iss_en=1 then sets busy[iss_addr]. Set wins over a same-cycle clear of the same address, because the new producer supersedes the old one.
  4. With ZERO_REG=1, bit 0 is held at 0.
- rd_busy[i] = busy[rd_addr[i]] && no wr_en port matches rd_addr[i] this cycle.
  - A same-cycle writeback therefore unblocks the reader, and rd_data carries the bypassed value.
  - A same-cycle iss_en does not affect rd_busy in that cycle.
- busy_cnt is a registered population count of the busy bits. It is updated in the same edge as the bits.

## Timing
- Reset (asynchronous, immediate):
  - All registers 0, all busy bits 0, busy_cnt 0.
  - rd_data reads 0 and rd_busy reads 0 until the first write or issue.
- Read latency: 0 cycles (combinational from rd_addr and wr_*).
- Write latency: 1 edge; the value is visible from the stored array the next cycle and through the bypass in the same cycle.
- Busy set latency: after an iss_en in cycle N, rd_busy is high in cycle N+1 onward.
- Busy clear latency: a matching writeback in cycle M drops rd_busy combinationally in cycle M.
- Reset asserted mid-operation overrides every pending write, issue and flush in that cycle.
- Writes are not gated by busy. A writeback to a non-busy register updates the data and leaves the bit at 0.

## Structure
- Shared package regfile_pkg:
  - defaults XLEN=32, DEPTH=32
  - an AW helper function ($clog2 wrapper)
  - a popcount function reused by other scoreboards
- Sub-module regfile_scoreboard holds:
  - the busy bits
  - the set/clear/flush priority
  - busy_cnt
- regfile_mp holds the array, write-port priority, bypass and rd_busy masking.
- Per-port slicing uses generate loops. No per-instance hand-coded ports.

## Test plan
- Reset mid-run with non-zero registers and busy bits set -> all rd_data=0, rd_busy=0, busy_cnt=0 immediately, before any clock edge.
- Write 0xDEADBEEF to reg 5 while rd_addr[0]=5 in the same cycle -> rd_data[0]=0xDEADBEEF that cycle and the next. Write to reg 0 with ZERO_REG=1 -> reads 0.
- NWRITE=2, both ports write reg 7 (0x11, then 0x22 on port 1) -> rd_data=0x22 in the bypass cycle and afterwards.
- iss_en to reg 3 in cycle N -> rd_busy high from N+1. Writeback to reg 3 in cycle M -> rd_busy=0 in cycle M. busy_cnt goes 0 -> 1 -> 0.
- In one cycle, writeback to reg 9 and iss_en to reg 9 with reg 9 already busy -> rd_busy=0 that cycle, rd_busy=1 next cycle, busy_cnt unchanged.
- Issue regs 1, 2, 3 over three cycles (busy_cnt=3), then flush together with iss_en to reg 4 -> busy_cnt=0 and no bits set next cycle.
